// File: rtl/div_seq_pkg.sv
// Shared definitions for the restoring-divide sequencer: FSM encoding,
// default operand width and the divide-by-zero quotient fill value.
package div_seq_pkg;

    localparam int DEF_WIDTH = 32;

    // Every quotient bit takes this value on divide-by-zero (all-ones result).
    localparam logic DIV0_QUOT_BIT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M,
// keep the difference and set the quotient bit when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] t;

    // A < M always holds, so the shifted A minus M fits in WIDTH+1 signed bits.
    assign a_sh = {a_i, q_i[WIDTH-1]};
    assign t    = a_sh - {1'b0, m_i};

    always_comb begin
        if (t[WIDTH]) begin
            a_o = a_sh[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end else begin
            a_o = t[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller around a one-bit-per-cycle restoring step;
// handles sign conversion, divide-by-zero and abort, and pulses done once.
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dvd_neg_q, dvd_neg_d, dvs_neg_q, dvs_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] step_a, step_q;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                // Raw operands parked in Q/M; PREP converts them in place.
                if (start && !abort) begin
                    dvd_neg_d = op_signed & dividend[WIDTH-1];
                    dvs_neg_d = op_signed & divisor[WIDTH-1];
                    q_d       = dividend;
                    m_d       = divisor;
                    a_d       = '0;
                    state_d   = S_PREP;
                end
            end
            S_PREP: begin
                if (m_q == '0) begin
                    quo_d   = {WIDTH{DIV0_QUOT_BIT}};
                    rem_d   = q_q;
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    m_d     = cond_neg(m_q, dvs_neg_q);
                    q_d     = cond_neg(q_q, dvd_neg_q);
                    a_d     = '0;
                    cnt_d   = CNT_INIT;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quo_d   = cond_neg(q_q, dvd_neg_q ^ dvs_neg_q);
                rem_d   = cond_neg(a_q, dvd_neg_q);
                dz_d    = 1'b0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort drops the operation without touching the visible results.
        if (abort) begin
            state_d = S_IDLE;
            quo_d   = quo_q;
            rem_d   = rem_q;
            dz_d    = dz_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
        end
    end

    assign busy        = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dz_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller that sequences a one-bit-per-cycle restoring divide datapath for the CPU's DIV/DIVU instructions. It accepts a start request from the control unit and handles operand sign conversion and divide-by-zero. It presents quotient (LO) and remainder (HI) with a one-cycle done pulse, which the control unit uses as the HI/LO write enable.

## Interface
- WIDTH, 32: operand/result width; must be ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in a cycle where busy=0.
- op_signed  in  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU); sampled on accept.
- dividend  in  WIDTH  sampled on accept.
- divisor  in  WIDTH  sampled on accept.
- abort  in  1  cancels the operation in flight (pipeline flush).
- busy  out  1  operation in progress (PREP/ITER/FIX).
- done  out  1  one-cycle pulse; results valid from this cycle.
- div_by_zero  out  1  valid with done; held until next done.
- quotient  out  WIDTH  held until next done.
- remainder  out  WIDTH  held until next done.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE/DONE: busy=0. start=1 and abort=0 → latch operands and sign → PREP.
  - DONE with no new start → IDLE.
- PREP:
  - divisor==0 → DONE with quotient=all-ones, remainder=dividend as latched (unconverted), div_by_zero=1.
  - Otherwise: M=|divisor|, Q=|dividend| (magnitudes when op_signed, raw when unsigned), A=0, count=WIDTH → ITER.
- ITER, one step per cycle:
  - {A,Q} shifted left 1.
  - T = A − M, computed WIDTH+1 bits wide.
  - T ≥ 0 → A=T, Q[0]=1; otherwise A unchanged, Q[0]=0.
  - count−1; leaving the cycle where count==1 → FIX.
- FIX:
  - quotient = Q, negated if op_signed and operand signs differ.
  - remainder = A[WIDTH−1:0], negated if op_signed and dividend negative (truncating division).
  - div_by_zero=0 → DONE.
- Overflow case: signed −2^(WIDTH−1) / −1 yields quotient=−2^(WIDTH−1), remainder=0. This falls out of the magnitude path and needs no special handling.
- start while busy=1: ignored, no queuing.
- Operand inputs are don't-care except in the accept cycle.
- abort=1 in any state → IDLE at next edge.
  - No done pulse.
  - quotient, remainder and div_by_zero keep their previous values.
  - abort beats a simultaneous start.

## Timing
- Reset (async assert): state IDLE.
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Internal A/Q/M/count cleared.
- Reset mid-operation: the operation is discarded silently.
- Start accepted in cycle 0:
  - PREP in cycle 1; ITER in cycles 2..WIDTH+1; FIX in cycle WIDTH+2.
  - done=1 in cycle WIDTH+3 (cycle 35 for WIDTH=32).
- Divide-by-zero: done=1 in cycle 2.
- busy=1 from cycle 1 through the FIX cycle. busy=0 in the DONE cycle.
- Back-to-back: a start in the DONE cycle is accepted, so throughput is one divide per WIDTH+3 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package div_seq_pkg holds:
  - state enum (IDLE, PREP, ITER, FIX, DONE);
  - default WIDTH;
  - divide-by-zero quotient constant (all-ones).
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: A, Q, M.
  - Outputs: next A, next Q.
  - Instantiated once inside ITER logic.
- Counter width: $clog2(WIDTH+1).

## Test plan
- Unsigned 100 / 7 → quotient=14, remainder=2, div_by_zero=0; done exactly in cycle 35; busy=1 in cycles 1..34 only.
- Signed quadrants, all with remainder taking the dividend's sign:
  - −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
  - −7 / −2 → quotient=3, remainder=0xFFFFFFFF.
- Divide-by-zero: dividend=0x12345678, divisor=0 → done in cycle 2, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- Extremes:
  - signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0;
  - unsigned 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0;
  - unsigned 5 / 9 → quotient=0, remainder=5.
- Abort and ignored start:
  - abort in cycle 10 → busy=0 in cycle 11, no done, previous results unchanged;
  - start pulsed during busy has no effect on the result.
- Reset and back-to-back:
  - rst asserted in cycle 20 → all outputs 0 immediately, state IDLE.
  - A new start issued in a DONE cycle completes WIDTH+3 cycles later with correct results.
